// File: rtl/sync_updown_counter_pkg.sv
// Shared counting definitions: direction encoding and the load-value clamp.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Out-of-range load values saturate to the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned d, input int unsigned modulus);
        return (d < modulus) ? d : modulus - 1;
    endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control/status bundle of one counter stage; master drives controls, slave is the counter.
interface sync_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             CLR;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic             EN;
    logic             UP;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             WRAP;

    modport master (output CLR, LOAD, D, EN, UP, input Q, TC, WRAP);
    modport slave  (input CLR, LOAD, D, EN, UP, output Q, TC, WRAP);
endinterface

// File: rtl/sync_updown_counter_tff_cell.sv
// Single T flip-flop bit cell with asynchronous active-low reset.
module tff_cell (
    output logic Q,
    input  logic T,
    input  logic CLK,
    input  logic RST_N
);
    logic r_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_q <= 1'b0;
        else if (T)
            r_q <= ~r_q;
    end

    assign Q = r_q;
endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter built from T cells; every update is applied as a toggle mask.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    sync_updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_chain;
    logic [WIDTH-1:0] w_load_val;
    logic             w_count;
    logic             w_wrap;
    logic             r_wrap;

    assign w_count    = bus.EN & ~bus.CLR & ~bus.LOAD;
    assign w_wrap     = w_count & (((bus.UP == DIR_UP)   && (w_q == MAX_Q)) ||
                                   ((bus.UP == DIR_DOWN) && (w_q == '0)));
    assign w_load_val = WIDTH'(clamp_load(32'(bus.D), MODULUS));

    // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
    always_comb begin : carry_chain
        logic w_carry;
        w_carry = 1'b1;
        w_chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_chain[i] = w_carry;
            w_carry    = w_carry & ((bus.UP == DIR_UP) ? w_q[i] : ~w_q[i]);
        end
    end

    always_comb begin
        w_next = w_q;
        if (bus.CLR)
            w_next = '0;
        else if (bus.LOAD)
            w_next = w_load_val;
        else if (w_wrap)
            w_next = (bus.UP == DIR_UP) ? '0 : MAX_Q;

        w_t = '0;
        if (bus.CLR || bus.LOAD || w_wrap)
            w_t = w_q ^ w_next;
        else if (bus.EN)
            w_t = w_chain;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .Q     (w_q[g]),
            .T     (w_t[g]),
            .CLK   (CLK),
            .RST_N (RST_N)
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_wrap;
    end

    assign bus.Q    = w_q;
    assign bus.TC   = w_wrap;
    assign bus.WRAP = r_wrap;
endmodule
